iter_arith_unit: RTL
====================

// Module: iter_arith_unit
// PURPOSE
//   Parametrised multi-cycle integer arithmetic unit with a start/busy handshake.
//   Successor to the fixed 8-bit single-function "fun" block.
//   Adds: generic WIDTH, runtime mode select (quotient, remainder, integer sqrt),
//   a done pulse and a divide-by-zero flag.
//   Sits behind a control FSM or testbench that drives start_i and waits for busy_o low.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be even and >= 4
// PORTS
//   clk_i    in   1      clock, all state updates on rising edge
//   rst_i    in   1      asynchronous, active-high reset
//   start_i  in   1      request; sampled only in IDLE
//   mode_bi  in   2      00 a/b quotient, 01 a%b remainder, 10 isqrt(a), 11 isqrt(b)
//   a_bi     in   WIDTH  operand A, unsigned
//   b_bi     in   WIDTH  operand B, unsigned
//   busy_o   out  1      high while an operation is in progress
//   done_o   out  1      one-cycle pulse when y_bo is updated
//   err_o    out  1      divide-by-zero flag for the last result
//   y_bo     out  WIDTH  result, held until the next completion
// BEHAVIOUR
//   Reset (async): state=IDLE, busy_o=0, done_o=0, err_o=0, y_bo=0; any operation in flight is discarded.
//   FSM states: IDLE, WORK.
//   IDLE:
//   - At an edge with start_i=1: latch a_bi, b_bi, mode_bi; clear the iteration counter; go to WORK; busy_o=1.
//   - Operand changes after the accept edge have no effect.
//   WORK:
//   - One iteration per cycle.
//   - ITER = WIDTH for modes 00/01 (restoring shift-subtract division).
//   - ITER = WIDTH/2 for modes 10/11 (digit-by-digit shift-subtract square root, no multiplier).
//   - Accept at edge N: last iteration at edge N+ITER. At that edge:
//     y_bo <= result; err_o <= (mode is 00 or 01) && b==0; done_o=1; busy_o=0; state=IDLE.
//   - busy_o is high for exactly ITER cycles.
//   - done_o is high for exactly 1 cycle (edge N+ITER to edge N+ITER+1).
//   - start_i is ignored while in WORK; requests are never queued.
//   - start_i held high continuously: next accept at edge N+ITER+1.
//     One cycle of IDLE between operations; throughput = 1 op per ITER+1 cycles.
//   Arithmetic:
//   - All values unsigned.
//   - Quotient and remainder are WIDTH bits; remainder < b when b != 0.
//   - isqrt is floor(sqrt(x)), zero-extended to WIDTH (uses WIDTH/2 bits).
//   Divide by zero (b=0, modes 00/01):
//   - Still runs the full ITER cycles.
//   - Quotient = all ones; remainder = a; err_o=1.
//   - Modes 10/11 never set err_o.
//   Hold behaviour:
//   - y_bo and err_o hold their values until the next completion.
//   - They do not change at accept or during WORK.
//   Mode 11 with b=0: y_bo=0. Mode 10 with a=0: y_bo=0.
// TESTING (WIDTH=8 unless noted)
//   1. a=23, b=8, mode 00 then 01 -> y_bo=2 then 7.
//      busy_o high for 8 cycles each; done_o one pulse each; err_o=0.
//   2. a=200, mode 10 -> y_bo=14 after 4 busy cycles.
//      a=255 -> 15. a=0 -> 0. b=144, mode 11 -> 12.
//   3. a=77, b=0, mode 00 -> y_bo=255, err_o=1.
//      Mode 01 -> y_bo=77, err_o=1.
//      Next op a=9, b=3, mode 00 -> y_bo=3, err_o=0.
//   4. start_i held high, operands changed every cycle -> accepts at edges N, N+9, N+18.
//      Each result matches the operands present at its accept edge.
//   5. rst_i pulsed at cycle 4 of a division -> all outputs 0 immediately.
//      Next start gives a correct, complete result.
//   6. WIDTH=16: 65535/255 -> 257 (16 busy cycles).
//      isqrt(65535) -> 255 (8 busy cycles).
//      Random 1000-vector sweep of all modes against a reference model.

Source files
------------

// File: rtl/iter_arith_unit.sv
// Multi-cycle unsigned arithmetic unit: restoring division (quotient or
// remainder) and digit-by-digit integer square root, one iteration per cycle.
//
// Handshake: start_i is sampled only while busy_o is low; a request seen at a
// rising edge is accepted at that edge and busy_o rises. busy_o stays high for
// exactly ITER cycles, after which y_bo/err_o update and done_o pulses for one
// cycle. start_i is ignored while busy_o is high and requests are never queued.
module iter_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_bi,
  input  logic [WIDTH-1:0] a_bi,
  input  logic [WIDTH-1:0] b_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] y_bo
);

  localparam int HW = WIDTH / 2;        // root width
  localparam int RW = WIDTH + 2;        // working width of the trial subtraction
  localparam int CW = $clog2(WIDTH);    // iteration counter width

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WORK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_finish;
  logic             w_last;

  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_b;       // divisor
  logic [WIDTH-1:0] r_q;       // dividend shifting out / quotient shifting in; radicand for sqrt
  logic [WIDTH-1:0] r_rem;     // partial remainder (division and sqrt)
  logic [HW-1:0]    r_root;    // partial root
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_y;
  logic             r_err;
  logic             r_done;

  logic [RW-1:0]    w_shift;
  logic [RW-1:0]    w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [HW-1:0]    w_root_nxt;
  logic [WIDTH-1:0] w_result;

  // Last iteration: WIDTH steps for division, WIDTH/2 steps for square root.
  assign w_last = (r_cnt == (r_mode[1] ? CW'(HW - 1) : CW'(WIDTH - 1)));

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WORK;
        end
      end
      S_WORK: begin
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One shift-subtract step. Both algorithms bring new bits into the partial
  // remainder and compare against a trial value: the divisor for division,
  // 4*root+1 for square root. Every kept remainder fits WIDTH bits: below the
  // divisor for division, at most 2*root for square root.
  always_comb begin
    w_shift    = '0;
    w_trial    = '0;
    w_q_nxt    = r_q;
    w_root_nxt = r_root;
    if (r_mode[1]) begin
      w_shift = {r_rem, r_q[WIDTH-1 -: 2]};
      w_trial = {{(RW - HW - 2){1'b0}}, r_root, 2'b01};
    end else begin
      w_shift = {1'b0, r_rem, r_q[WIDTH-1]};
      w_trial = {2'b00, r_b};
    end
    w_ge      = (w_shift >= w_trial);
    w_rem_nxt = w_ge ? WIDTH'(w_shift - w_trial) : WIDTH'(w_shift);
    if (r_mode[1]) begin
      w_q_nxt    = {r_q[WIDTH-3:0], 2'b00};
      w_root_nxt = {r_root[HW-2:0], w_ge};
    end else begin
      w_q_nxt    = {r_q[WIDTH-2:0], w_ge};
    end
    // Divide by zero needs no special case: every trial succeeds, so the
    // quotient fills with ones and the remainder reassembles a.
    case (r_mode)
      2'b00:   w_result = w_q_nxt;
      2'b01:   w_result = w_rem_nxt;
      default: w_result = {{(WIDTH - HW){1'b0}}, w_root_nxt};
    endcase
  end

  // Datapath: latch operands on accept, iterate while working.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode <= '0;
      r_b    <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_mode <= mode_bi;
      r_b    <= b_bi;
      r_q    <= (mode_bi == 2'b11) ? b_bi : a_bi;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_WORK) begin
      r_q    <= w_q_nxt;
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Result registers: updated only on completion, held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_y    <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_y   <= w_result;
        r_err <= ~r_mode[1] && (r_b == '0);
      end
    end
  end

  assign busy_o = (r_state == S_WORK);
  assign done_o = r_done;
  assign err_o  = r_err;
  assign y_bo   = r_y;

endmodule
